// File: rtl/time_tube_driver.sv
// Scans eight seven-segment tubes as two 4-tube groups from a packed BCD time word.
// Optional separator blinking is enabled by defining TIME_SEP_BLINK_EN.
module time_tube_driver #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_data,
  output logic [7:0]  digit1,
  output logic [7:0]  digit2,
  output logic [7:0]  tube_sel
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DIV_W    = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] divider;
  logic             tick;
  logic [1:0]       idx;
  logic [1:0]       nxt;
  logic             started;
  logic [31:0]      snapshot;
  logic [31:0]      src;
  logic [3:0]       left_nib;
  logic [3:0]       right_nib;
  logic             blink_on;

  function automatic logic [7:0] enc(input logic [3:0] nib, input logic sep_on);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hFC;
      4'h1:    seg = 8'h60;
      4'h2:    seg = 8'hDA;
      4'h3:    seg = 8'hF2;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'hB6;
      4'h6:    seg = 8'hBE;
      4'h7:    seg = 8'hE0;
      4'h8:    seg = 8'hFE;
      4'h9:    seg = 8'hF6;
      4'hF:    seg = sep_on ? 8'h02 : 8'h00;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  assign tick = (divider == DIV_W'(SCAN_DIV - 1));
  assign nxt  = started ? idx + 2'd1 : 2'd0;
  // The idx0 step reads time_data live so a new frame shows on the same tick it is latched.
  assign src  = (nxt == 2'd0) ? time_data : snapshot;

  always_comb begin
    left_nib  = src[31:28];
    right_nib = src[15:12];
    case (nxt)
      2'd1: begin
        left_nib  = src[27:24];
        right_nib = src[11:8];
      end
      2'd2: begin
        left_nib  = src[23:20];
        right_nib = src[7:4];
      end
      2'd3: begin
        left_nib  = src[19:16];
        right_nib = src[3:0];
      end
      default: begin
        left_nib  = src[31:28];
        right_nib = src[15:12];
      end
    endcase
  end

`ifdef TIME_SEP_BLINK_EN
  localparam int BLINK_W = $clog2(CLK_HZ);

  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_W'(CLK_HZ - 1)) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  assign blink_on = (blink_cnt < BLINK_W'(CLK_HZ / 2));
`else
  assign blink_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divider <= '0;
    end else if (tick) begin
      divider <= '0;
    end else begin
      divider <= divider + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= 2'd0;
      started  <= 1'b0;
      snapshot <= 32'h0;
      digit1   <= 8'h00;
      digit2   <= 8'h00;
      tube_sel <= 8'h00;
    end else if (tick) begin
      idx      <= nxt;
      started  <= 1'b1;
      if (nxt == 2'd0) begin
        snapshot <= time_data;
      end
      digit1   <= enc(left_nib, blink_on);
      digit2   <= enc(right_nib, blink_on);
      tube_sel <= 8'b1000_1000 >> nxt;
    end
  end

endmodule

// File: tb/tb_time_tube_driver.sv
// Bench for time_tube_driver: directed frame checks plus randomized time_data and resets
// against a cycle-count based reference model.
module tb_time_tube_driver;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int SDIV    = CLK_HZ / SCAN_HZ;

  logic        clk;
  logic        rst;
  logic [31:0] time_data;
  logic [7:0]  digit1;
  logic [7:0]  digit2;
  logic [7:0]  tube_sel;

  int n_chk;
  int n_fail;

  time_tube_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .time_data (time_data),
    .digit1    (digit1),
    .digit2    (digit2),
    .tube_sel  (tube_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: step number is derived purely from cycles since reset release.
  int unsigned m_cyc;
  logic [31:0] m_snap;
  logic [7:0]  m_d1;
  logic [7:0]  m_d2;
  logic [7:0]  m_ts;

  function automatic logic [7:0] m_enc(input logic [3:0] nib, input bit sep_on);
    logic [7:0] glyph [10];
    glyph = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    if (nib < 4'd10) return glyph[nib];
    if (nib == 4'hF) return sep_on ? 8'h02 : 8'h00;
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int ix;
    logic [31:0] msrc;
    bit bl;
    if (!rst) begin
      m_cyc  = 0;
      m_snap = 32'h0;
      m_d1   = 8'h00;
      m_d2   = 8'h00;
      m_ts   = 8'h00;
    end else begin
      m_cyc++;
      if (m_cyc % SDIV == 0) begin
        ix = int'((m_cyc / SDIV - 1) % 4);
        if (ix == 0) m_snap = time_data;
        msrc = m_snap;
        bl = 1'b1;
`ifdef TIME_SEP_BLINK_EN
        bl = ((m_cyc - 1) % CLK_HZ) < (CLK_HZ / 2);
`endif
        m_d1 = m_enc(msrc[31-4*ix -: 4], bl);
        m_d2 = m_enc(msrc[15-4*ix -: 4], bl);
        m_ts = 8'h88 >> ix;
      end
    end
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("model_d1", digit1, m_d1);
      chk("model_d2", digit2, m_d2);
      chk("model_ts", tube_sel, m_ts);
    end
  endtask

  task automatic expect3(input string tag, input logic [7:0] ts, input logic [7:0] d1,
                         input logic [7:0] d2);
    chk({tag, "_ts"}, tube_sel, ts);
    chk({tag, "_d1"}, digit1, d1);
    chk({tag, "_d2"}, digit2, d2);
  endtask

  logic [7:0] t2_ts [4];
  logic [7:0] t2_d1 [4];
  logic [7:0] t2_d2 [4];

  initial begin
    int waited;
    n_chk  = 0;
    n_fail = 0;
    t2_ts = '{8'h88, 8'h44, 8'h22, 8'h11};
    t2_d1 = '{8'hFC, 8'hFC, 8'h02, 8'hFC};
    t2_d2 = '{8'hF2, 8'h02, 8'hB6, 8'hF6};

    rst       = 1'b0;
    time_data = 32'h0;
    repeat (3) @(negedge clk);
    expect3("in_reset", 8'h00, 8'h00, 8'h00);
    rst = 1'b1;

    // First tick lands exactly SCAN_DIV cycles after release.
    step(9);
    expect3("pre_tick", 8'h00, 8'h00, 8'h00);
    step(1);
    expect3("first_tick", 8'h88, 8'hFC, 8'hFC);

    time_data = 32'h00F0_3F59;
    step(40);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(SDIV);
      expect3("frame", t2_ts[i], t2_d1[i], t2_d2[i]);
    end
    step(SDIV);
    expect3("frame_repeat", t2_ts[0], t2_d1[0], t2_d2[0]);
    step(SDIV);

    // Mid-frame change must not show until the next idx0 step.
    time_data = 32'h1111_1111;
    step(SDIV);
    expect3("midframe_idx2", 8'h22, 8'h02, 8'hB6);
    step(SDIV);
    expect3("midframe_idx3", 8'h11, 8'hFC, 8'hF6);
    step(SDIV);
    expect3("new_frame", 8'h88, 8'h60, 8'h60);

    time_data = 32'hABCD_EABC;
    step(40);
    expect3("blank_idx0", 8'h88, 8'h00, 8'h00);
    step(SDIV);
    expect3("blank_idx1", 8'h44, 8'h00, 8'h00);

    step(SDIV + 4);
    expect3("pre_rst_idx2", 8'h22, 8'h00, 8'h00);
    rst = 1'b0;
    #1;
    expect3("async_rst", 8'h00, 8'h00, 8'h00);
    time_data = 32'h7000_2000;
    step(3);
    rst = 1'b1;
    step(9);
    expect3("post_rst_wait", 8'h00, 8'h00, 8'h00);
    step(1);
    expect3("post_rst_tick", 8'h88, 8'hE0, 8'hDA);

    // Separator phase spans more than one blink period.
    time_data = 32'h00F0_0F00;
    step(1200);
    waited = 0;
    while (m_ts != 8'h44 && waited < 50) begin
      step(1);
      waited++;
    end
    chk("sep_wait_ts", m_ts, 8'h44);
`ifndef TIME_SEP_BLINK_EN
    chk("sep_steady", digit2, 8'h02);
`endif
    chk("sep_digit", digit1, 8'hFC);

    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) time_data = $urandom;
      if ($urandom_range(0, 1499) == 0) begin
        rst = 1'b0;
        step($urandom_range(1, 4));
        rst = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
